// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between I and D cache engines; AXI_RD_ARB_RR_EN enables round-robin
module axi_rd_arbiter #(
    parameter int             IW   = 4,
    parameter logic [IW-1:0]  I_ID = 4'h0,
    parameter logic [IW-1:0]  D_ID = 4'h1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          i_arvalid,
    input  logic [31:0]   i_araddr,
    input  logic [3:0]    i_arlen,
    output logic          i_arready,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_rlast,
    input  logic          i_rready,
    input  logic          d_arvalid,
    input  logic [31:0]   d_araddr,
    input  logic [3:0]    d_arlen,
    output logic          d_arready,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_rlast,
    input  logic          d_rready,
    output logic [IW-1:0] arid,
    output logic [31:0]   araddr,
    output logic [3:0]    arlen,
    output logic [2:0]    arsize,
    output logic [1:0]    arburst,
    output logic          arvalid,
    input  logic          arready,
    input  logic [IW-1:0] rid,
    input  logic [31:0]   rdata,
    input  logic [1:0]    rresp,
    input  logic          rlast,
    input  logic          rvalid,
    output logic          rready,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t          state, state_n;
    logic [1:0]      grant_q;
    logic [31:0]     araddr_q;
    logic [3:0]      arlen_q, cnt;
    logic [IW-1:0]   arid_q;
    logic            err_q, req, d_win, beat, beat_err, stray;
    assign req = i_arvalid | d_arvalid;
`ifdef AXI_RD_ARB_RR_EN
    logic last_d;
    assign d_win = d_arvalid & (~i_arvalid | ~last_d);
    // remember which port won the most recent grant so ties alternate
    always_ff @(posedge aclk or posedge areset)
        if (areset) last_d <= 1'b0;
        else if (state == IDLE && req) last_d <= d_win;
`else
    assign d_win = d_arvalid;
`endif
    assign beat     = (state == DATA) & rvalid & rready;
    assign stray    = rvalid & (state != DATA);
    assign beat_err = (rid != arid_q) | (rresp != 2'b00) | (rlast & (cnt != arlen_q)) | ((cnt == arlen_q) & ~rlast);
    assign arid     = arid_q;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign grant    = grant_q;
    assign busy     = state != IDLE;
    assign err      = err_q;
    assign i_rdata  = rdata;
    assign d_rdata  = rdata;
    // state register
    always_ff @(posedge aclk or posedge areset)
        if (areset) state <= IDLE;
        else state <= state_n;
    // next state and channel steering toward the granted port
    always_comb begin
        state_n   = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rlast   = 1'b0;
        d_rlast   = 1'b0;
        case (state)
            IDLE: state_n = req ? ADDR : IDLE;
            ADDR: begin
                arvalid   = 1'b1;
                i_arready = grant_q[0] & arready;
                d_arready = grant_q[1] & arready;
                state_n   = arready ? DATA : ADDR;
            end
            DATA: begin
                rready   = grant_q[1] ? d_rready : i_rready;
                i_rvalid = grant_q[0] & rvalid;
                d_rvalid = grant_q[1] & rvalid;
                i_rlast  = grant_q[0] & rlast;
                d_rlast  = grant_q[1] & rlast;
                state_n  = (rvalid & rready & rlast) ? IDLE : DATA;
            end
            default: state_n = IDLE;
        endcase
    end
    // latch the winning request, count beats and capture sticky protocol errors
    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            grant_q  <= 2'b00;
            araddr_q <= '0;
            arlen_q  <= '0;
            arid_q   <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                grant_q  <= {d_win, ~d_win};
                araddr_q <= d_win ? d_araddr : i_araddr;
                arlen_q  <= d_win ? d_arlen : i_arlen;
                arid_q   <= d_win ? D_ID : I_ID;
                cnt      <= '0;
            end
            if (beat) cnt <= cnt + 4'd1;
            if (beat & rlast) grant_q <= 2'b00;
            if ((beat & beat_err) | stray) err_q <= 1'b1;
        end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench for axi_rd_arbiter; AXI_RD_ARB_RR_EN selects round-robin expectations
module tb_axi_rd_arbiter;
    localparam int IW = 4;
    logic          aclk = 1'b0, areset = 1'b0;
    logic          i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
    logic          d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
    logic [31:0]   i_araddr, d_araddr, i_rdata, d_rdata, araddr, rdata;
    logic [3:0]    i_arlen, d_arlen, arlen;
    logic [IW-1:0] arid, rid;
    logic [2:0]    arsize;
    logic [1:0]    arburst, rresp, grant;
    logic          arvalid, arready, rlast, rvalid, rready, busy, err;
    int            passed = 0, total = 0;

    axi_rd_arbiter #(.IW(IW), .I_ID(4'h0), .D_ID(4'h1)) dut (
        .aclk(aclk), .areset(areset),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arready(d_arready),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready), .grant(grant), .busy(busy), .err(err)
    );

    always #5 aclk = ~aclk;

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs;
        i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_rready = 1;
        d_arvalid = 0; d_araddr = 0; d_arlen = 0; d_rready = 1;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    endtask

    task automatic request(input bit is_d, input logic [31:0] a, input logic [3:0] l);
        if (is_d) begin d_arvalid = 1; d_araddr = a; d_arlen = l; end
        else begin i_arvalid = 1; i_araddr = a; i_arlen = l; end
    endtask

    task automatic ar_hs(input bit is_d);
        arready = 1;
        step;
        arready = 0;
        if (is_d) d_arvalid = 0; else i_arvalid = 0;
    endtask

    task automatic burst(input int n, input logic [IW-1:0] id);
        for (int b = 0; b <= n; b++) begin
            rvalid = 1; rid = id; rdata = 32'hA000_0000 + b; rlast = (b == n);
            step;
        end
        rvalid = 0; rlast = 0;
    endtask

    task automatic pulse_reset;
        areset = 1; #1; areset = 0;
    endtask

    task automatic test_reset;
        clear_inputs;
        #1 areset = 1;
        #1;
        total++; if ({busy, err, arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid} !== 8'h00)
            $display("FAIL reset_ctrl got %b want %b", {busy, err, arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid}, 8'h00); else passed++;
        total++; if (grant !== 2'b00) $display("FAIL reset_grant got %b want %b", grant, 2'b00); else passed++;
        total++; if ({araddr, arlen, arid} !== 40'h0) $display("FAIL reset_regs got %h want %h", {araddr, arlen, arid}, 40'h0); else passed++;
        total++; if ({arsize, arburst} !== 5'b010_01) $display("FAIL reset_const got %b want %b", {arsize, arburst}, 5'b010_01); else passed++;
        step;
        areset = 0;
        step;
    endtask

    task automatic test_single_i;
        request(0, 32'h1FC0_0000, 7);
        #1;
        total++; if ({arvalid, i_arready} !== 2'b00) $display("FAIL single_latency got %b want %b", {arvalid, i_arready}, 2'b00); else passed++;
        step;
        total++; if ({arvalid, grant} !== 3'b1_01) $display("FAIL single_ar got %b want %b", {arvalid, grant}, 3'b1_01); else passed++;
        total++; if ({araddr, arlen, arid} !== {32'h1FC0_0000, 4'd7, 4'h0}) $display("FAIL single_ar_regs got %h want %h", {araddr, arlen, arid}, {32'h1FC0_0000, 4'd7, 4'h0}); else passed++;
        arready = 1;
        #1;
        total++; if ({i_arready, d_arready} !== 2'b10) $display("FAIL single_arready got %b want %b", {i_arready, d_arready}, 2'b10); else passed++;
        step;
        arready = 0; i_arvalid = 0;
        for (int b = 0; b < 8; b++) begin
            rvalid = 1; rid = 0; rdata = 32'h0000_1000 + b; rlast = (b == 7);
            #1;
            total++; if ({i_rvalid, d_rvalid, i_rlast, rready} !== {1'b1, 1'b0, b == 7, 1'b1})
                $display("FAIL single_beat%0d got %b want %b", b, {i_rvalid, d_rvalid, i_rlast, rready}, {1'b1, 1'b0, b == 7, 1'b1}); else passed++;
            total++; if (i_rdata !== 32'h0000_1000 + b) $display("FAIL single_data%0d got %h want %h", b, i_rdata, 32'h0000_1000 + b); else passed++;
            step;
        end
        rvalid = 0; rlast = 0;
        total++; if ({busy, err, grant} !== 4'b0000) $display("FAIL single_end got %b want %b", {busy, err, grant}, 4'b0000); else passed++;
    endtask

    task automatic test_simultaneous;
        request(0, 32'h0000_2000, 0);
        request(1, 32'h0000_3000, 0);
        step;
        total++; if ({grant, arid} !== {2'b10, 4'h1}) $display("FAIL tie_d_first got %h want %h", {grant, arid}, {2'b10, 4'h1}); else passed++;
        total++; if (araddr !== 32'h0000_3000) $display("FAIL tie_d_addr got %h want %h", araddr, 32'h0000_3000); else passed++;
        ar_hs(1);
        total++; if (i_arready !== 1'b0) $display("FAIL tie_i_wait got %b want %b", i_arready, 1'b0); else passed++;
        rvalid = 1; rid = 1; rlast = 1; rdata = 32'h55;
        #1;
        total++; if ({d_rvalid, i_rvalid} !== 2'b10) $display("FAIL tie_d_route got %b want %b", {d_rvalid, i_rvalid}, 2'b10); else passed++;
        step;
        rvalid = 0; rlast = 0;
        total++; if ({grant, arvalid, busy} !== 4'b0000) $display("FAIL tie_bubble got %b want %b", {grant, arvalid, busy}, 4'b0000); else passed++;
        step;
        total++; if ({grant, arid, araddr} !== {2'b01, 4'h0, 32'h0000_2000}) $display("FAIL tie_i_second got %h want %h", {grant, arid, araddr}, {2'b01, 4'h0, 32'h0000_2000}); else passed++;
        ar_hs(0);
        burst(0, 4'h0);
        total++; if ({err, busy} !== 2'b00) $display("FAIL tie_end got %b want %b", {err, busy}, 2'b00); else passed++;
    endtask

    task automatic test_tie_after_d;
        logic [1:0] exp;
`ifdef AXI_RD_ARB_RR_EN
        exp = 2'b01;
`else
        exp = 2'b10;
`endif
        request(1, 32'h0000_4000, 0);
        step;
        ar_hs(1);
        burst(0, 4'h1);
        request(0, 32'h0000_5000, 0);
        request(1, 32'h0000_6000, 0);
        step;
        total++; if (grant !== exp) $display("FAIL tie2_winner got %b want %b", grant, exp); else passed++;
        ar_hs(exp[1]);
        burst(0, {3'b0, exp[1]});
        step;
        total++; if (grant !== {exp[0], exp[1]}) $display("FAIL tie2_loser got %b want %b", grant, {exp[0], exp[1]}); else passed++;
        ar_hs(exp[0]);
        burst(0, {3'b0, exp[0]});
        total++; if ({err, busy} !== 2'b00) $display("FAIL tie2_end got %b want %b", {err, busy}, 2'b00); else passed++;
    endtask

    task automatic test_backpressure;
        request(1, 32'h0000_7000, 3);
        step;
        for (int c = 0; c < 5; c++) begin
            total++; if ({arvalid, d_arready, araddr} !== {1'b1, 1'b0, 32'h0000_7000})
                $display("FAIL bp_ar%0d got %h want %h", c, {arvalid, d_arready, araddr}, {1'b1, 1'b0, 32'h0000_7000}); else passed++;
            step;
        end
        ar_hs(1);
        for (int c = 0; c <= 6; c++) begin
            d_rready = (c % 2 == 0); rvalid = 1; rid = 1; rlast = (c / 2 == 3); rdata = c / 2;
            #1;
            total++; if ({rready, d_rvalid} !== {d_rready, 1'b1}) $display("FAIL bp_r%0d got %b want %b", c, {rready, d_rvalid}, {d_rready, 1'b1}); else passed++;
            step;
        end
        rvalid = 0; rlast = 0; d_rready = 1;
        total++; if ({err, busy} !== 2'b00) $display("FAIL bp_count got %b want %b", {err, busy}, 2'b00); else passed++;
    endtask

    task automatic test_early_rlast;
        request(0, 32'h0000_8000, 3);
        step;
        ar_hs(0);
        for (int b = 0; b < 3; b++) begin
            rvalid = 1; rid = 0; rlast = (b == 2); rdata = b;
            step;
        end
        rvalid = 0; rlast = 0;
        total++; if ({err, busy} !== 2'b10) $display("FAIL early_err got %b want %b", {err, busy}, 2'b10); else passed++;
        step; step;
        total++; if (err !== 1'b1) $display("FAIL early_sticky got %b want %b", err, 1'b1); else passed++;
        pulse_reset;
        total++; if (err !== 1'b0) $display("FAIL early_clear got %b want %b", err, 1'b0); else passed++;
    endtask

    task automatic test_wrong_rid;
        request(1, 32'h0000_9000, 0);
        step;
        ar_hs(1);
        rvalid = 1; rid = 0; rlast = 1; rdata = 32'hDEAD_BEEF;
        #1;
        total++; if ({d_rvalid, i_rvalid} !== 2'b10) $display("FAIL rid_route got %b want %b", {d_rvalid, i_rvalid}, 2'b10); else passed++;
        total++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL rid_data got %h want %h", d_rdata, 32'hDEAD_BEEF); else passed++;
        step;
        rvalid = 0; rlast = 0;
        total++; if ({err, busy} !== 2'b10) $display("FAIL rid_err got %b want %b", {err, busy}, 2'b10); else passed++;
        pulse_reset;
    endtask

    task automatic test_stray;
        step;
        rvalid = 1;
        #1;
        total++; if ({rready, i_rvalid, d_rvalid} !== 3'b000) $display("FAIL stray_block got %b want %b", {rready, i_rvalid, d_rvalid}, 3'b000); else passed++;
        step;
        rvalid = 0;
        total++; if (err !== 1'b1) $display("FAIL stray_err got %b want %b", err, 1'b1); else passed++;
        pulse_reset;
    endtask

    task automatic test_reset_mid;
        request(0, 32'h0000_A000, 7);
        step;
        ar_hs(0);
        for (int b = 0; b < 3; b++) begin
            rvalid = 1; rid = 0; rlast = 0; rdata = b;
            step;
        end
        rvalid = 1;
        areset = 1;
        #1;
        total++; if ({busy, grant, arvalid, rready, i_rvalid, d_rvalid, err} !== 8'h00)
            $display("FAIL mid_ctrl got %b want %b", {busy, grant, arvalid, rready, i_rvalid, d_rvalid, err}, 8'h00); else passed++;
        total++; if ({araddr, arlen, arid} !== 40'h0) $display("FAIL mid_regs got %h want %h", {araddr, arlen, arid}, 40'h0); else passed++;
        rvalid = 0;
        areset = 0;
        request(1, 32'h0000_B000, 1);
        step;
        total++; if ({grant, arid, araddr} !== {2'b10, 4'h1, 32'h0000_B000}) $display("FAIL mid_regrant got %h want %h", {grant, arid, araddr}, {2'b10, 4'h1, 32'h0000_B000}); else passed++;
        ar_hs(1);
        burst(1, 4'h1);
        total++; if ({err, busy} !== 2'b00) $display("FAIL mid_end got %b want %b", {err, busy}, 2'b00); else passed++;
    endtask

    initial begin
        test_reset;
        test_single_i;
        test_simultaneous;
        test_tie_after_d;
        test_backpressure;
        test_early_rlast;
        test_wrong_rid;
        test_stray;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
